// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous RAM.
// CPU has priority; each port is masked in its own DONE and ack cycles so the other port cannot starve.
module mem_port_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned MEM_AW    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_dma
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ISS  = 3'd1,
        CPU_DONE = 3'd2,
        DMA_ISS  = 3'd3,
        DMA_DONE = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic lat_we_q;
    logic lat_ok_q;
    logic lat_we_d;
    logic lat_ok_d;

    logic              arb_c;
    logic              cpu_live_c;
    logic              dma_live_c;
    logic              grant_cpu_c;
    logic              grant_dma_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic              sel_ok_c;

    logic [MEM_AW-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_we_d;
    logic              mem_re_d;
    logic [DATA_W-1:0] cpu_rdata_d;
    logic              cpu_ack_d;
    logic              cpu_err_d;
    logic [DATA_W-1:0] dma_rdata_d;
    logic              dma_ack_d;
    logic              dma_err_d;
    logic              busy_d;
    logic              grant_dma_d;

    // Arbitration: a port is masked in its own DONE cycle and in its ack cycle.
    assign arb_c       = (state_q == IDLE) || (state_q == CPU_DONE) || (state_q == DMA_DONE);
    assign cpu_live_c  = cpu_req && (state_q != CPU_DONE) && !cpu_ack;
    assign dma_live_c  = dma_req && (state_q != DMA_DONE) && !dma_ack;
    assign grant_cpu_c = arb_c && cpu_live_c;
    assign grant_dma_c = arb_c && dma_live_c && !cpu_live_c;

    assign sel_we_c    = grant_dma_c ? dma_we    : cpu_we;
    assign sel_addr_c  = grant_dma_c ? dma_addr  : cpu_addr;
    assign sel_wdata_c = grant_dma_c ? dma_wdata : cpu_wdata;
    assign sel_ok_c    = (32'(sel_addr_c) < MEM_WORDS);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CPU_DONE, DMA_DONE: begin
                if (grant_cpu_c) begin
                    state_d = CPU_ISS;
                end else if (grant_dma_c) begin
                    state_d = DMA_ISS;
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_ISS: state_d = CPU_DONE;
            DMA_ISS: state_d = DMA_DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; strobes are launched at the grant edge so they are live during ISS.
    always_comb begin
        lat_we_d    = lat_we_q;
        lat_ok_d    = lat_ok_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        cpu_rdata_d = cpu_rdata;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        dma_rdata_d = dma_rdata;
        dma_ack_d   = 1'b0;
        dma_err_d   = 1'b0;
        grant_dma_d = grant_dma;
        busy_d      = (state_d != IDLE);

        if (grant_cpu_c || grant_dma_c) begin
            lat_we_d    = sel_we_c;
            lat_ok_d    = sel_ok_c;
            grant_dma_d = grant_dma_c;
            if (sel_ok_c) begin
                mem_addr_d = MEM_AW'(sel_addr_c);
                if (sel_we_c) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = sel_wdata_c;
                end else begin
                    mem_re_d = 1'b1;
                end
            end
        end

        case (state_q)
            CPU_DONE: begin
                cpu_ack_d = 1'b1;
                cpu_err_d = !lat_ok_q;
                if (!lat_we_q) begin
                    cpu_rdata_d = lat_ok_q ? mem_rdata : '0;
                end
            end
            DMA_DONE: begin
                dma_ack_d = 1'b1;
                dma_err_d = !lat_ok_q;
                if (!lat_we_q) begin
                    dma_rdata_d = lat_ok_q ? mem_rdata : '0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and latched request attributes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we_q  <= 1'b0;
            lat_ok_q  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            dma_rdata <= '0;
            dma_ack   <= 1'b0;
            dma_err   <= 1'b0;
            busy      <= 1'b0;
            grant_dma <= 1'b0;
        end else begin
            lat_we_q  <= lat_we_d;
            lat_ok_q  <= lat_ok_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_we    <= mem_we_d;
            mem_re    <= mem_re_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_ack   <= cpu_ack_d;
            cpu_err   <= cpu_err_d;
            dma_rdata <= dma_rdata_d;
            dma_ack   <= dma_ack_d;
            dma_err   <= dma_err_d;
            busy      <= busy_d;
            grant_dma <= grant_dma_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned MEM_WORDS = 512;
    localparam int unsigned MEM_AW    = 9;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;
    logic              dma_err;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              grant_dma;

    logic [DATA_W-1:0] ram [MEM_WORDS];

    int checks;
    int failures;

    mem_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy), .grant_dma(grant_dma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data valid the cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [2*DATA_W+MEM_AW+DATA_W+8-1:0] outs;
        logic seen_ack;
        reset = 1'b0;
        cyc(2);
        outs = {mem_addr, mem_wdata, mem_we, mem_re, cpu_rdata, dma_rdata,
                cpu_ack, dma_ack, cpu_err, dma_err, busy, grant_dma};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_state outputs=%h expected 0", outs);
        end
        reset = 1'b1;
        cyc(1);
        // CPU read request at t, reset asserted mid CPU_ISS
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        cyc(1);
        checks++;
        if (mem_re !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_iss mem_re=%b expected 1", mem_re);
        end
        reset = 1'b0;
        #1;
        outs = {mem_addr, mem_wdata, mem_we, mem_re, cpu_rdata, dma_rdata,
                cpu_ack, dma_ack, cpu_err, dma_err, busy, grant_dma};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_async outputs=%h expected 0", outs);
        end
        cpu_req = 1'b0;
        cyc(1);
        reset = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (cpu_ack || mem_re || mem_we) seen_ack = 1'b1;
        end
        checks++;
        if (seen_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_abandon activity=%b expected 0", seen_ack);
        end
    endtask

    task automatic test_cpu_read();
        ram[9'h010] = 32'hDEADBEEF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        cyc(1);
        checks++;
        if ({mem_re, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 9'h010, 1'b1}) begin
            failures++;
            $display("FAIL cpu_read_iss re/we/addr/busy=%b/%b/%h/%b expected 1/0/010/1",
                     mem_re, mem_we, mem_addr, busy);
        end
        cyc(1);
        checks++;
        if ({mem_re, mem_we, cpu_ack} !== 3'b000) begin
            failures++;
            $display("FAIL cpu_read_done re/we/ack=%b%b%b expected 000", mem_re, mem_we, cpu_ack);
        end
        cyc(1);
        checks++;
        if ({cpu_ack, cpu_err, cpu_rdata, dma_ack} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL cpu_read_ack ack/err/rdata/dma_ack=%b/%b/%h/%b expected 1/0/deadbeef/0",
                     cpu_ack, cpu_err, cpu_rdata, dma_ack);
        end
        cpu_req = 1'b0;
        cyc(1);
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL cpu_read_after ack/rdata=%b/%h expected 0/deadbeef", cpu_ack, cpu_rdata);
        end
        cyc(2);
    endtask

    task automatic test_dma_write_cpu_read();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0020; dma_wdata = 32'h12345678;
        cyc(1);
        checks++;
        if ({mem_we, mem_re, mem_addr, mem_wdata, grant_dma} !== {1'b1, 1'b0, 9'h020, 32'h12345678, 1'b1}) begin
            failures++;
            $display("FAIL dma_write_iss we/re/addr/wdata/gd=%b/%b/%h/%h/%b expected 1/0/020/12345678/1",
                     mem_we, mem_re, mem_addr, mem_wdata, grant_dma);
        end
        cyc(2);
        checks++;
        if ({dma_ack, dma_err, cpu_ack} !== 3'b100) begin
            failures++;
            $display("FAIL dma_write_ack ack/err/cpu_ack=%b%b%b expected 100", dma_ack, dma_err, cpu_ack);
        end
        dma_req = 1'b0;
        checks++;
        if (ram[9'h020] !== 32'h12345678) begin
            failures++;
            $display("FAIL dma_write_ram ram=%h expected 12345678", ram[9'h020]);
        end
        cyc(2);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        cyc(3);
        checks++;
        if ({cpu_ack, cpu_rdata, grant_dma} !== {1'b1, 32'h12345678, 1'b0}) begin
            failures++;
            $display("FAIL cpu_readback ack/rdata/gd=%b/%h/%b expected 1/12345678/0",
                     cpu_ack, cpu_rdata, grant_dma);
        end
        cpu_req = 1'b0;
        cyc(2);
    endtask

    task automatic test_simultaneous();
        int both;
        both = 0;
        ram[9'h001] = 32'hA1A1A1A1;
        ram[9'h002] = 32'hB2B2B2B2;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0002;
        cyc(1);
        if (mem_re && mem_we) both++;
        checks++;
        if ({mem_re, mem_addr, grant_dma} !== {1'b1, 9'h001, 1'b0}) begin
            failures++;
            $display("FAIL simul_cpu_iss re/addr/gd=%b/%h/%b expected 1/001/0", mem_re, mem_addr, grant_dma);
        end
        cyc(1);
        if (mem_re && mem_we) both++;
        cyc(1);
        if (mem_re && mem_we) both++;
        checks++;
        if ({mem_re, mem_addr, grant_dma, cpu_ack, cpu_rdata, dma_ack}
            !== {1'b1, 9'h002, 1'b1, 1'b1, 32'hA1A1A1A1, 1'b0}) begin
            failures++;
            $display("FAIL simul_dma_iss re/addr/gd/cack/crd/dack=%b/%h/%b/%b/%h/%b expected 1/002/1/1/a1a1a1a1/0",
                     mem_re, mem_addr, grant_dma, cpu_ack, cpu_rdata, dma_ack);
        end
        cpu_req = 1'b0;
        cyc(1);
        if (mem_re && mem_we) both++;
        checks++;
        if ({cpu_ack, dma_ack} !== 2'b00) begin
            failures++;
            $display("FAIL simul_gap cack/dack=%b%b expected 00", cpu_ack, dma_ack);
        end
        cyc(1);
        if (mem_re && mem_we) both++;
        checks++;
        if ({dma_ack, dma_err, dma_rdata} !== {1'b1, 1'b0, 32'hB2B2B2B2}) begin
            failures++;
            $display("FAIL simul_dma_ack ack/err/rdata=%b/%b/%h expected 1/0/b2b2b2b2",
                     dma_ack, dma_err, dma_rdata);
        end
        dma_req = 1'b0;
        checks++;
        if (both !== 0) begin
            failures++;
            $display("FAIL simul_strobes both_high_cycles=%0d expected 0", both);
        end
        cyc(2);
    endtask

    task automatic test_out_of_range();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
        cyc(1);
        checks++;
        if ({mem_re, mem_we, mem_addr} !== {1'b0, 1'b0, 9'h002}) begin
            failures++;
            $display("FAIL oor_cpu_iss re/we/addr=%b/%b/%h expected 0/0/002", mem_re, mem_we, mem_addr);
        end
        cyc(2);
        checks++;
        if ({cpu_ack, cpu_err, cpu_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL oor_cpu_ack ack/err/rdata=%b/%b/%h expected 1/1/00000000",
                     cpu_ack, cpu_err, cpu_rdata);
        end
        cpu_req = 1'b0;
        cyc(1);
        checks++;
        if ({cpu_ack, cpu_err} !== 2'b00) begin
            failures++;
            $display("FAIL oor_cpu_pulse ack/err=%b%b expected 00", cpu_ack, cpu_err);
        end
        cyc(1);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hFFFF; dma_wdata = 32'hCAFEF00D;
        cyc(1);
        checks++;
        if ({mem_we, mem_re, mem_wdata} !== {1'b0, 1'b0, 32'h12345678}) begin
            failures++;
            $display("FAIL oor_dma_iss we/re/wdata=%b/%b/%h expected 0/0/12345678", mem_we, mem_re, mem_wdata);
        end
        cyc(2);
        checks++;
        if ({dma_ack, dma_err, dma_rdata} !== {1'b1, 1'b1, 32'hB2B2B2B2}) begin
            failures++;
            $display("FAIL oor_dma_ack ack/err/rdata=%b/%b/%h expected 1/1/b2b2b2b2",
                     dma_ack, dma_err, dma_rdata);
        end
        dma_req = 1'b0;
        cyc(2);
    endtask

    task automatic test_fairness();
        logic exp_re, exp_gd, exp_cack, exp_dack;
        ram[9'h030] = 32'hC0C0C0C0;
        ram[9'h040] = 32'hD0D0D0D0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0040;
        // CPU ISS at t+1,5,9,13; DMA ISS at t+3,7,11; acks two cycles after each ISS
        for (int i = 1; i <= 13; i++) begin
            cyc(1);
            exp_re   = (i % 2) == 1;
            exp_gd   = (i % 4) == 3;
            exp_cack = (i % 4) == 3;
            exp_dack = (i >= 5) && ((i % 4) == 1);
            checks++;
            if ({mem_re, mem_we, cpu_ack, dma_ack} !== {exp_re, 1'b0, exp_cack, exp_dack}) begin
                failures++;
                $display("FAIL fair_cycle%0d re/we/cack/dack=%b%b%b%b expected %b0%b%b",
                         i, mem_re, mem_we, cpu_ack, dma_ack, exp_re, exp_cack, exp_dack);
            end
            if (exp_re) begin
                checks++;
                if (grant_dma !== exp_gd) begin
                    failures++;
                    $display("FAIL fair_grant%0d grant_dma=%b expected %b", i, grant_dma, exp_gd);
                end
            end
            if (exp_cack) begin
                checks++;
                if (cpu_rdata !== 32'hC0C0C0C0) begin
                    failures++;
                    $display("FAIL fair_crd%0d cpu_rdata=%h expected c0c0c0c0", i, cpu_rdata);
                end
            end
            if (exp_dack) begin
                checks++;
                if (dma_rdata !== 32'hD0D0D0D0) begin
                    failures++;
                    $display("FAIL fair_drd%0d dma_rdata=%h expected d0d0d0d0", i, dma_rdata);
                end
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        cyc(6);
        checks++;
        if ({busy, cpu_ack, dma_ack} !== 3'b000) begin
            failures++;
            $display("FAIL fair_drain busy/cack/dack=%b%b%b expected 000", busy, cpu_ack, dma_ack);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] = '0;
        test_reset();
        test_cpu_read();
        test_dma_write_cpu_read();
        test_simultaneous();
        test_out_of_range();
        test_fairness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
